// File: rtl/question_block_controller_pkg.sv
// Shared definitions for the question-block controller.
// Holds the block FSM state type, the room codes, the block size and the
// bump-animation offset table used by each block instance.
package question_block_controller_pkg;

  localparam int COORD_W    = 10;
  localparam int ADDR_W     = 9;
  localparam int LEVEL_W    = 3;
  localparam int BLOCK_SIZE = 16;

  localparam logic [LEVEL_W-1:0] ROOM1 = 3'b001;
  localparam logic [LEVEL_W-1:0] ROOM3 = 3'b011;

  typedef enum logic [1:0] {
    QB_FULL  = 2'd0,
    QB_BUMP  = 2'd1,
    QB_EMPTY = 2'd2
  } qblock_state_t;

  // Upward draw offset (pixels) for each bump frame: rise to 8, fall back to 0.
  function automatic logic [3:0] bump_offset(input logic [2:0] cnt);
    logic [3:0] off;
    case (cnt)
      3'd0:    off = 4'd2;
      3'd1:    off = 4'd4;
      3'd2:    off = 4'd6;
      3'd3:    off = 4'd8;
      3'd4:    off = 4'd6;
      3'd5:    off = 4'd4;
      3'd6:    off = 4'd2;
      default: off = 4'd0;
    endcase
    return off;
  endfunction

endpackage

// File: rtl/question_block_controller_if.sv
// Bus bundle between the video/game logic and the question-block controller.
// Ports: frame_clk, pixel position, active level, player positions/rising
// flags in; per-room empty flags, pixel hit flag and sprite address out.
interface question_block_controller_if;
  import question_block_controller_pkg::*;

  logic               frame_clk;
  logic [COORD_W-1:0] DrawX;
  logic [COORD_W-1:0] DrawY;
  logic [LEVEL_W-1:0] level_num;
  logic [COORD_W-1:0] mario_x;
  logic [COORD_W-1:0] mario_y;
  logic [COORD_W-1:0] luigi_x;
  logic [COORD_W-1:0] luigi_y;
  logic               mario_rising;
  logic               luigi_rising;
  logic               is_question_empty_room1;
  logic               is_question_empty_room3;
  logic               is_question;
  logic [ADDR_W-1:0]  question_address;

  // Driver side (game logic / testbench).
  modport master (
    output frame_clk, DrawX, DrawY, level_num,
    output mario_x, mario_y, luigi_x, luigi_y, mario_rising, luigi_rising,
    input  is_question_empty_room1, is_question_empty_room3,
    input  is_question, question_address
  );

  // Controller side.
  modport slave (
    input  frame_clk, DrawX, DrawY, level_num,
    input  mario_x, mario_y, luigi_x, luigi_y, mario_rising, luigi_rising,
    output is_question_empty_room1, is_question_empty_room3,
    output is_question, question_address
  );

endinterface

// File: rtl/question_block_controller_question_block.sv
// One question block: FULL -> BUMP -> EMPTY FSM, bump counter, head-hit
// detection and pixel hit / sprite address generation.
// Ports: clk_i/rst_ni, tick_i (frame strobe), level/players/pixel in;
// empty_o, is_question_o, address_o out. Pixel outputs are combinational.
module question_block
  import question_block_controller_pkg::*;
#(
  parameter int                 BX   = 100,
  parameter int                 BY   = 326,
  parameter logic [LEVEL_W-1:0] ROOM = ROOM1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               tick_i,
  input  logic [LEVEL_W-1:0] level_num_i,
  input  logic [COORD_W-1:0] mario_x_i,
  input  logic [COORD_W-1:0] mario_y_i,
  input  logic [COORD_W-1:0] luigi_x_i,
  input  logic [COORD_W-1:0] luigi_y_i,
  input  logic               mario_rising_i,
  input  logic               luigi_rising_i,
  input  logic [COORD_W-1:0] draw_x_i,
  input  logic [COORD_W-1:0] draw_y_i,
  output logic               empty_o,
  output logic               is_question_o,
  output logic [ADDR_W-1:0]  address_o
);

  localparam logic [10:0] BX_W   = 11'(BX);
  localparam logic [10:0] BY_W   = 11'(BY);
  localparam logic [10:0] SPAN_W = 11'(BLOCK_SIZE - 1);

  // Head inside the block's bottom band while moving up. Widened to 11 bits
  // so px+15 and BY+16 cannot wrap.
  function automatic logic head_hit(input logic [COORD_W-1:0] px,
                                    input logic [COORD_W-1:0] py,
                                    input logic               rising);
    logic [10:0] x;
    logic [10:0] y;
    x = {1'b0, px};
    y = {1'b0, py};
    return rising
        && (x + SPAN_W >= BX_W)
        && (x <= BX_W + SPAN_W)
        && (y >= BY_W + 11'd8)
        && (y <= BY_W + 11'(BLOCK_SIZE));
  endfunction

  qblock_state_t state_q;
  logic [2:0]    cnt_q;

  logic active;
  logic hit;

  assign active = (level_num_i == ROOM);
  // Both players striking on the same tick collapse into one hit.
  assign hit = head_hit(mario_x_i, mario_y_i, mario_rising_i)
            || head_hit(luigi_x_i, luigi_y_i, luigi_rising_i);

  // A block outside the active room is frozen: no hit, no counter advance.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= QB_FULL;
      cnt_q   <= 3'd0;
    end else if (tick_i && active) begin
      case (state_q)
        QB_FULL: begin
          if (hit) begin
            state_q <= QB_BUMP;
            cnt_q   <= 3'd0;
          end
        end
        QB_BUMP: begin
          if (cnt_q == 3'd7) begin
            state_q <= QB_EMPTY;
            cnt_q   <= 3'd0;
          end else begin
            cnt_q <= cnt_q + 3'd1;
          end
        end
        default: ; // EMPTY is terminal until reset
      endcase
    end
  end

  assign empty_o = (state_q == QB_EMPTY);

  logic [3:0]  offset;
  logic [10:0] top_y;
  logic [10:0] rel_x;
  logic [10:0] rel_y;
  logic        on_blk;

  assign offset = (state_q == QB_BUMP) ? bump_offset(cnt_q) : 4'd0;
  assign top_y  = BY_W - {7'd0, offset};
  assign rel_x  = {1'b0, draw_x_i} - BX_W;
  assign rel_y  = {1'b0, draw_y_i} - top_y;

  // Read as signed: in [0,15] exactly when the upper seven bits are zero;
  // negative differences carry a set sign bit and fall outside.
  assign on_blk = (rel_x[10:4] == 7'd0) && (rel_y[10:4] == 7'd0);

  assign is_question_o = on_blk;
  assign address_o     = on_blk ? {empty_o, rel_y[3:0], rel_x[3:0]} : '0;

endmodule

// File: rtl/question_block_controller.sv
// Question-block controller: synchronises the vsync frame tick, runs the
// room-1 and room-3 blocks, and muxes the active room's pixel outputs.
// Ports: Clk, Reset (async active-low), bus (slave modport of the if).
module question_block_controller
  import question_block_controller_pkg::*;
#(
  parameter int BLK1_X = 100,
  parameter int BLK1_Y = 326,
  parameter int BLK3_X = 100,
  parameter int BLK3_Y = 326
) (
  input logic                       Clk,
  input logic                       Reset,
  question_block_controller_if.slave bus
);

  // Two flops to synchronise vsync, a third to find its rising edge.
  logic [2:0] fsync_q;
  logic       tick;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      fsync_q <= 3'b000;
    end else begin
      fsync_q <= {fsync_q[1:0], bus.frame_clk};
    end
  end

  assign tick = fsync_q[1] & ~fsync_q[2];

  logic              empty1, empty3;
  logic              isq1, isq3;
  logic [ADDR_W-1:0] addr1, addr3;

  question_block #(.BX(BLK1_X), .BY(BLK1_Y), .ROOM(ROOM1)) u_blk1 (
    .clk_i          (Clk),
    .rst_ni         (Reset),
    .tick_i         (tick),
    .level_num_i    (bus.level_num),
    .mario_x_i      (bus.mario_x),
    .mario_y_i      (bus.mario_y),
    .luigi_x_i      (bus.luigi_x),
    .luigi_y_i      (bus.luigi_y),
    .mario_rising_i (bus.mario_rising),
    .luigi_rising_i (bus.luigi_rising),
    .draw_x_i       (bus.DrawX),
    .draw_y_i       (bus.DrawY),
    .empty_o        (empty1),
    .is_question_o  (isq1),
    .address_o      (addr1)
  );

  question_block #(.BX(BLK3_X), .BY(BLK3_Y), .ROOM(ROOM3)) u_blk3 (
    .clk_i          (Clk),
    .rst_ni         (Reset),
    .tick_i         (tick),
    .level_num_i    (bus.level_num),
    .mario_x_i      (bus.mario_x),
    .mario_y_i      (bus.mario_y),
    .luigi_x_i      (bus.luigi_x),
    .luigi_y_i      (bus.luigi_y),
    .mario_rising_i (bus.mario_rising),
    .luigi_rising_i (bus.luigi_rising),
    .draw_x_i       (bus.DrawX),
    .draw_y_i       (bus.DrawY),
    .empty_o        (empty3),
    .is_question_o  (isq3),
    .address_o      (addr3)
  );

  logic              isq_sel;
  logic [ADDR_W-1:0] addr_sel;

  always_comb begin
    isq_sel  = 1'b0;
    addr_sel = '0;
    case (bus.level_num)
      ROOM1: begin
        isq_sel  = isq1;
        addr_sel = addr1;
      end
      ROOM3: begin
        isq_sel  = isq3;
        addr_sel = addr3;
      end
      default: ;
    endcase
  end

  assign bus.is_question_empty_room1 = empty1;
  assign bus.is_question_empty_room3 = empty3;
  assign bus.is_question             = isq_sel;
  assign bus.question_address        = addr_sel;

endmodule

// File: tb/tb_question_block_controller.sv
// Directed bench for question_block_controller: reset state, bump offset
// sequence, room gating, double/re-hit, mid-bump reset and pixel addressing.
module tb_question_block_controller;

  logic clk;
  logic rst_n;
  int   vec_cnt;
  int   miscompare_cnt;

  question_block_controller_if bus();

  question_block_controller dut (
    .Clk   (clk),
    .Reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_vec(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miscompare_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Address seen at DrawX=BX, DrawY=BY: rel_y equals the bump offset.
  function automatic logic [31:0] off_addr(input int off);
    logic [3:0] o;
    o = 4'(off);
    return {23'd0, 1'b0, o, 4'd0};
  endfunction

  // One vsync pulse; the state update lands well before the final negedge.
  task automatic do_tick();
    @(negedge clk);
    bus.frame_clk = 1'b1;
    repeat (4) @(negedge clk);
    bus.frame_clk = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic set_players(input logic [9:0] mx, input logic [9:0] my,
                             input logic mr, input logic [9:0] lx,
                             input logic [9:0] ly, input logic lr);
    bus.mario_x = mx; bus.mario_y = my; bus.mario_rising = mr;
    bus.luigi_x = lx; bus.luigi_y = ly; bus.luigi_rising = lr;
  endtask

  task automatic set_pix(input logic [9:0] x, input logic [9:0] y);
    bus.DrawX = x;
    bus.DrawY = y;
    #1;
  endtask

  int bump_tbl [8] = '{2, 4, 6, 8, 6, 4, 2, 0};

  initial begin
    vec_cnt = 0;
    miscompare_cnt = 0;
    rst_n = 1'b0;
    bus.frame_clk = 1'b0;
    bus.level_num = 3'b001;
    set_players(10'd0, 10'd0, 1'b0, 10'd0, 10'd0, 1'b0);
    set_pix(10'd100, 10'd326);

    // Reset state
    repeat (3) @(negedge clk);
    check_vec("rst_empty1", 32'(bus.is_question_empty_room1), 32'd0);
    check_vec("rst_empty3", 32'(bus.is_question_empty_room3), 32'd0);
    check_vec("rst_isq", 32'(bus.is_question), 32'd1);
    check_vec("rst_addr", 32'(bus.question_address), 32'd0);
    rst_n = 1'b1;

    // Idle frames with nobody near the blocks
    repeat (20) do_tick();
    check_vec("idle_empty1", 32'(bus.is_question_empty_room1), 32'd0);
    check_vec("idle_empty3", 32'(bus.is_question_empty_room3), 32'd0);
    check_vec("idle_addr", 32'(bus.question_address), 32'd0);

    // In position but not rising: no bump
    set_players(10'd100, 10'd336, 1'b0, 10'd0, 10'd0, 1'b0);
    do_tick();
    check_vec("norise_addr", 32'(bus.question_address), off_addr(0));

    // Level 3 with a hit: room-3 block bumps, room-1 untouched
    bus.level_num = 3'b011;
    set_players(10'd100, 10'd336, 1'b1, 10'd0, 10'd0, 1'b0);
    do_tick();
    set_players(10'd100, 10'd336, 1'b0, 10'd0, 10'd0, 1'b0);
    set_pix(10'd100, 10'd326);
    check_vec("r3_bump_addr", 32'(bus.question_address), off_addr(2));
    bus.level_num = 3'b001;
    #1;
    check_vec("r1_untouched", 32'(bus.question_address), off_addr(0));

    // Both players hit together, then a re-hit mid-bump
    set_players(10'd100, 10'd336, 1'b1, 10'd95, 10'd342, 1'b1);
    do_tick();
    set_players(10'd100, 10'd336, 1'b0, 10'd95, 10'd342, 1'b0);
    check_vec("bump_off0", 32'(bus.question_address), off_addr(bump_tbl[0]));
    for (int i = 1; i < 8; i++) begin
      bus.mario_rising = (i == 3);
      do_tick();
      bus.mario_rising = 1'b0;
      check_vec($sformatf("bump_off%0d", i), 32'(bus.question_address),
                off_addr(bump_tbl[i]));
    end
    check_vec("pre_empty1", 32'(bus.is_question_empty_room1), 32'd0);
    do_tick();
    check_vec("empty1_set", 32'(bus.is_question_empty_room1), 32'd1);
    check_vec("empty3_clr", 32'(bus.is_question_empty_room3), 32'd0);
    check_vec("empty_addr", 32'(bus.question_address), 32'h100);

    // Room-3 counter froze while level 1 was active
    bus.level_num = 3'b011;
    #1;
    check_vec("r3_frozen", 32'(bus.question_address), off_addr(2));

    // Pixel addressing on the spent block and its edges
    bus.level_num = 3'b001;
    set_pix(10'd103, 10'd331);
    check_vec("pix_isq", 32'(bus.is_question), 32'd1);
    check_vec("pix_addr", 32'(bus.question_address), 32'h153);
    set_pix(10'd99, 10'd331);
    check_vec("pix_left_off", 32'(bus.is_question), 32'd0);
    check_vec("pix_left_addr", 32'(bus.question_address), 32'd0);
    set_pix(10'd115, 10'd341);
    check_vec("pix_corner", 32'(bus.question_address), 32'h1ff);
    set_pix(10'd116, 10'd331);
    check_vec("pix_right_off", 32'(bus.is_question), 32'd0);
    set_pix(10'd103, 10'd342);
    check_vec("pix_bottom_off", 32'(bus.is_question), 32'd0);
    set_pix(10'd103, 10'd331);
    bus.level_num = 3'b010;
    #1;
    check_vec("lvl2_isq", 32'(bus.is_question), 32'd0);
    check_vec("lvl2_addr", 32'(bus.question_address), 32'd0);

    // Fresh reset, bump to count 4, then reset mid-bump
    bus.level_num = 3'b001;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_vec("rst2_empty1", 32'(bus.is_question_empty_room1), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    set_pix(10'd100, 10'd326);
    set_players(10'd100, 10'd336, 1'b1, 10'd0, 10'd0, 1'b0);
    do_tick();
    set_players(10'd100, 10'd336, 1'b0, 10'd0, 10'd0, 1'b0);
    repeat (4) do_tick();
    check_vec("cnt4_off", 32'(bus.question_address), off_addr(6));
    @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_vec("midrst_addr", 32'(bus.question_address), off_addr(0));
    check_vec("midrst_empty1", 32'(bus.is_question_empty_room1), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    set_players(10'd100, 10'd336, 1'b1, 10'd0, 10'd0, 1'b0);
    do_tick();
    set_players(10'd100, 10'd336, 1'b0, 10'd0, 10'd0, 1'b0);
    check_vec("rehit_off", 32'(bus.question_address), off_addr(2));

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompare_cnt);
    $finish;
  end

endmodule

// File: doc/question_block_controller.md
# question_block_controller

Tracks the two question blocks (room 1 and room 3) through full, bump-animation and empty states, and drives the `is_question_empty_room1/room3` flags that gate upgrade spawning downstream. Detects a rising player's head striking a block bottom, once per frame tick. Produces the per-pixel block hit flag and 9-bit sprite ROM address for the colour mapper.

## Interface
- `BLK1_X`, default 100: room-1 block left edge, pixels.
- `BLK1_Y`, default 326: room-1 block top edge, pixels.
- `BLK3_X`, default 100: room-3 block left edge.
- `BLK3_Y`, default 326: room-3 block top edge.
- `Clk  in  1`: system clock, 50 MHz; one clock.
- `Reset  in  1`: asynchronous, active-low; asserted at 0.
- `frame_clk  in  1`: VGA vsync, asynchronous to nothing but treated as a data input.
- `DrawX, DrawY  in  10 each`: current pixel.
- `level_num  in  3`: active room.
- `mario_x, mario_y, luigi_x, luigi_y  in  10 each`: player left edge / top edge.
- `mario_rising, luigi_rising  in  1 each`: player vertical velocity is upward this frame.
- `is_question_empty_room1, is_question_empty_room3  out  1 each`: block has finished its bump and is spent.
- `is_question  out  1`: DrawX/DrawY lies on the active room's block.
- `question_address  out  9`: sprite ROM address.

## Operation
- Frame tick: `frame_clk` passes a 2-flop synchronizer; tick is a one-`Clk` pulse on its rising edge. All state updates happen only on tick.
- Per block, FSM: FULL → BUMP → EMPTY. EMPTY is terminal until reset.
- FULL→BUMP on tick when `level_num` equals the block's room (3'b001 or 3'b011) and either player hits.
- Hit, per player: rising=1 and px+15 ≥ BX and px ≤ BX+15 and py ≥ BY+8 and py ≤ BY+16. All compares in 11-bit unsigned to avoid wrap.
- Both players hitting on the same tick count as one hit. A hit on a block in BUMP or EMPTY is ignored.
- BUMP: 3-bit frame counter starts at 0 on entry and increments per tick. Vertical offset by count 0..7 is 2, 4, 6, 8, 6, 4, 2, 0 pixels (block drawn higher by offset). On the tick with count=7, go to EMPTY.
- `is_question_empty_roomN` = state is EMPTY.
- Room change: state persists; a block not in the active room freezes (no counter advance while `level_num` ≠ its room).
- Pixel output, combinational from DrawX/DrawY and registered state. Active block is selected by `level_num`; other levels give `is_question`=0 and address 0.
- On-block when DrawX−BX ∈ [0,15] and DrawY−(BY−offset) ∈ [0,15], computed 11-bit signed.
- `question_address` = {empty_bit, rel_y[3:0], rel_x[3:0]}. empty_bit=1 in EMPTY, 0 in FULL/BUMP. The address is 0 when `is_question`=0.

## Timing
- Reset (asynchronous): both FSMs FULL, counters 0, synchronizer flops 0, empty flags 0; `is_question` and address follow combinationally from DrawX/DrawY.
- Hit to BUMP: visible on the `Clk` after the tick, i.e. ~2–3 `Clk` after the vsync edge.
- Empty flag asserts 8 ticks after the BUMP entry tick.
- Reset mid-BUMP returns to FULL immediately; the empty flag stays 0.
- Pixel outputs have zero latency relative to DrawX/DrawY, matching the upgrade pipeline alignment.

## Structure
- Shared package holds `qblock_state_t` enum (FULL, BUMP, EMPTY), the room codes (ROOM1=3'b001, ROOM3=3'b011), the block size (16), and the bump-offset function.
- One sub-module, `question_block`, is instantiated twice. It contains FSM, counter, hit detection and pixel/address generation, and takes BX/BY/room as parameters. The top level holds the synchronizer and the `level_num` output mux.

## Test plan
- Reset release, no hits, 20 ticks → both empty flags 0; DrawX=100, DrawY=326, level 1 → `is_question`=1, address 0.
- Level 1, mario_x=100, mario_y=336, rising=1 for one tick → offsets 2,4,6,8,6,4,2,0 on successive ticks; `is_question_empty_room1`=1 after the 8th; room 3 stays 0.
- Same position with rising=0, or with level_num=3'b011 → no state change.
- Mario and Luigi both hit on the same tick → single bump sequence. Re-hit during BUMP → sequence length unchanged.
- Reset low at bump count 4 → immediately FULL, flag 0; a new hit restarts from offset 2.
- EMPTY block, DrawX=103, DrawY=331 → address 9'h153; level 3'b010 → `is_question`=0, address 0.
